// File: rtl/csr_file_m.sv
// rtl/csr_file_m.sv - machine-mode CSR file with atomic CSRRW/CSRRS/CSRRC, trap state and counters
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   : 64-bit mcycle/minstret plus shadows and (XLEN=32) high halves
//   undefined : counter addresses stay legal, read 0, ignore writes; no counter flops
//
// Ports:
//   clk_i, rst_i          rising-edge clock, asynchronous active-high reset
//   csr_addr_i/op_i       CSR address and op (00 none, 01 RW, 10 RS, 11 RC)
//   csr_wdata_i           rs1/zimm operand
//   csr_rdata_o           old CSR value (combinational, 0 when no op or illegal)
//   csr_illegal_o         access illegal (combinational)
//   trap_i + cause/pc/val trap entry this cycle
//   mret_i                MRET this cycle
//   retire_i              one instruction retires this cycle
//   mtvec_o/mepc_o/mie_o  trap vector, return PC, mstatus.MIE
module csr_file_m #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [31:0]     MISA_VAL    = 32'h4000_0100,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            retire_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] rd_val;
    logic            mapped;
    logic            wants_write;
    logic            do_write;
    logic [XLEN-1:0] wval;

    logic [XLEN-1:0] cyc_lo;
    logic [XLEN-1:0] cyc_hi;
    logic [XLEN-1:0] ins_lo;
    logic [XLEN-1:0] ins_hi;

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie_q;
        mstatus_val[3]     = mie_q;
    end

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (csr_addr_i)
            ADDR_MSTATUS:              rd_val = mstatus_val;
            ADDR_MISA:                 rd_val = XLEN'(MISA_VAL);
            ADDR_MTVEC:                rd_val = mtvec_q;
            ADDR_MSCRATCH:             rd_val = mscratch_q;
            ADDR_MEPC:                 rd_val = mepc_q;
            ADDR_MCAUSE:               rd_val = mcause_q;
            ADDR_MTVAL:                rd_val = mtval_q;
            ADDR_MCYCLE, ADDR_CYCLE:   rd_val = cyc_lo;
            ADDR_MINSTRET, ADDR_INSTRET: rd_val = ins_lo;
            // High halves only exist when a counter does not fit in one register.
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                if (XLEN == 32) rd_val = cyc_hi;
                else            mapped = 1'b0;
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                if (XLEN == 32) rd_val = ins_hi;
                else            mapped = 1'b0;
            end
            ADDR_MHARTID:              rd_val = HART_ID;
            default:                   mapped = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it is legal on read-only CSRs.
    assign wants_write   = (csr_op_i == OP_RW) ||
                           ((csr_op_i != OP_NONE) && (csr_wdata_i != '0));
    assign csr_illegal_o = (csr_op_i != OP_NONE) &&
                           (!mapped || ((csr_addr_i[11:10] == 2'b11) && wants_write));
    assign csr_rdata_o   = ((csr_op_i != OP_NONE) && !csr_illegal_o) ? rd_val : '0;

    always_comb begin
        wval = csr_wdata_i;
        case (csr_op_i)
            OP_RS:   wval = rd_val | csr_wdata_i;
            OP_RC:   wval = rd_val & ~csr_wdata_i;
            default: wval = csr_wdata_i;
        endcase
    end

    // Trap and MRET take the cycle; any CSR write alongside them is dropped.
    assign do_write = wants_write && !csr_illegal_o && !trap_i && !mret_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_i) begin
            mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause_i;
            mtval_q  <= trap_val_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (do_write) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    mie_q  <= wval[3];
                    mpie_q <= wval[7];
                end
                ADDR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_q <= wval;
                ADDR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_q   <= wval;
                ADDR_MTVAL:    mtval_q    <= wval;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic        wr_cyc_lo;
    logic        wr_cyc_hi;
    logic        wr_ins_lo;
    logic        wr_ins_hi;

    // High-half addresses are unmapped at XLEN=64, so do_write never fires for them there.
    assign wr_cyc_lo = do_write && (csr_addr_i == ADDR_MCYCLE);
    assign wr_cyc_hi = do_write && (csr_addr_i == ADDR_MCYCLEH);
    assign wr_ins_lo = do_write && (csr_addr_i == ADDR_MINSTRET);
    assign wr_ins_hi = do_write && (csr_addr_i == ADDR_MINSTRETH);

    // A written counter holds the written half this cycle instead of counting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_cyc_lo)      mcycle_q[XLEN-1:0] <= wval;
            else if (wr_cyc_hi) mcycle_q[63:32]    <= wval[31:0];
            else                mcycle_q           <= mcycle_q + 64'd1;

            if (wr_ins_lo)      minstret_q[XLEN-1:0] <= wval;
            else if (wr_ins_hi) minstret_q[63:32]    <= wval[31:0];
            else if (retire_i)  minstret_q           <= minstret_q + 64'd1;
        end
    end

    assign cyc_lo = mcycle_q[XLEN-1:0];
    assign cyc_hi = XLEN'(mcycle_q[63:32]);
    assign ins_lo = minstret_q[XLEN-1:0];
    assign ins_hi = XLEN'(minstret_q[63:32]);
`else
    logic unused_retire;

    assign cyc_lo        = '0;
    assign cyc_hi        = '0;
    assign ins_lo        = '0;
    assign ins_hi        = '0;
    assign unused_retire = retire_i;
`endif

    // The PC is word aligned on entry; its low bits are discarded.
    logic unused_pc_bits;
    assign unused_pc_bits = ^trap_pc_i[1:0];

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_file_m.sv
// tb/tb_csr_file_m.sv - self-checking bench for csr_file_m with per-cycle reference model
module tb_csr_file_m;

    localparam logic [31:0] HART       = 32'h0000_0005;
    localparam logic [31:0] MISA       = 32'h4000_0100;
    localparam logic [31:0] RST_MTVEC  = 32'h0000_0207;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_val_i;
    logic        mret_i;
    logic        retire_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    int vecs = 0;
    int errs = 0;

    csr_file_m #(
        .XLEN        (32),
        .HART_ID     (HART),
        .MISA_VAL    (MISA),
        .RESET_MTVEC (RST_MTVEC)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .csr_addr_i    (csr_addr_i),
        .csr_op_i      (csr_op_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_illegal_o (csr_illegal_o),
        .trap_i        (trap_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .trap_val_i    (trap_val_i),
        .mret_i        (mret_i),
        .retire_i      (retire_i),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .mie_o         (mie_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mscratch, m_mepc, m_mcause, m_mtval, m_mtvec;
    bit          m_mie, m_mpie;
    logic [63:0] m_cyc, m_ins;

    task automatic m_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = RST_MTVEC & ~32'h3;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic bit is_mapped(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
            12'hF14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return MISA;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00, 12'hC00: return CNT_EN ? m_cyc[31:0]  : 32'h0;
            12'hB02, 12'hC02: return CNT_EN ? m_ins[31:0]  : 32'h0;
            12'hB80, 12'hC80: return CNT_EN ? m_cyc[63:32] : 32'h0;
            12'hB82, 12'hC82: return CNT_EN ? m_ins[63:32] : 32'h0;
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk_i) begin : compare
        logic [31:0] old_v, new_v, e_rd;
        bit wr, ill, cyc_w, ins_w;
        if (rst_i) m_reset();
        wr    = (csr_op_i == 2'd1) || (csr_op_i != 2'd0 && csr_wdata_i != 32'h0);
        ill   = (csr_op_i != 2'd0) &&
                (!is_mapped(csr_addr_i) || (csr_addr_i[11:10] == 2'b11 && wr));
        old_v = m_read(csr_addr_i);
        e_rd  = (csr_op_i != 2'd0 && !ill) ? old_v : 32'h0;
        check("cmp_rdata",   csr_rdata_o,            e_rd);
        check("cmp_illegal", {31'b0, csr_illegal_o}, {31'b0, ill});
        check("cmp_mtvec",   mtvec_o,                m_mtvec);
        check("cmp_mepc",    mepc_o,                 m_mepc);
        check("cmp_mie",     {31'b0, mie_o},         {31'b0, m_mie});
        if (!rst_i) begin
            cyc_w = 0; ins_w = 0;
            if (trap_i) begin
                m_mepc = trap_pc_i & ~32'h3; m_mcause = trap_cause_i; m_mtval = trap_val_i;
                m_mpie = m_mie; m_mie = 0;
            end else if (mret_i) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (csr_op_i != 2'd0 && !ill && wr) begin
                case (csr_op_i)
                    2'd2:    new_v = old_v | csr_wdata_i;
                    2'd3:    new_v = old_v & ~csr_wdata_i;
                    default: new_v = csr_wdata_i;
                endcase
                case (csr_addr_i)
                    12'h300: begin m_mie = new_v[3]; m_mpie = new_v[7]; end
                    12'h305: m_mtvec = new_v & ~32'h3;
                    12'h340: m_mscratch = new_v;
                    12'h341: m_mepc = new_v & ~32'h3;
                    12'h342: m_mcause = new_v;
                    12'h343: m_mtval = new_v;
                    12'hB00: if (CNT_EN) begin m_cyc[31:0]  = new_v; cyc_w = 1; end
                    12'hB80: if (CNT_EN) begin m_cyc[63:32] = new_v; cyc_w = 1; end
                    12'hB02: if (CNT_EN) begin m_ins[31:0]  = new_v; ins_w = 1; end
                    12'hB82: if (CNT_EN) begin m_ins[63:32] = new_v; ins_w = 1; end
                    default: ;
                endcase
            end
            if (!cyc_w) m_cyc = m_cyc + 1;
            if (!ins_w && retire_i) m_ins = m_ins + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic [2:0] ctl);
        @(posedge clk_i); #1;
        csr_addr_i = a; csr_op_i = op; csr_wdata_i = wd;
        trap_i = ctl[2]; mret_i = ctl[1]; retire_i = ctl[0];
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        csr_addr_i = 0; csr_op_i = 0; csr_wdata_i = 0;
        trap_i = 0; mret_i = 0; retire_i = 0;
        trap_cause_i = 32'hB; trap_pc_i = 32'h83; trap_val_i = 32'h5;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        step(12'h000, 2'd0, 0, 3'b000);
        check("reset_mie",   {31'b0, mie_o}, 32'h0);
        check("reset_mtvec", mtvec_o, 32'h204);
        check("reset_mepc",  mepc_o, 32'h0);

        step(12'h340, 2'd1, 32'hDEAD_BEEF, 3'b000);
        check("rw_mscratch_legal", {31'b0, csr_illegal_o}, 32'h0);
        step(12'h340, 2'd2, 32'h0000_0010, 3'b000);
        check("rs_reads_old", csr_rdata_o, 32'hDEAD_BEEF);
        step(12'h340, 2'd3, 32'hDEAD_0000, 3'b000);
        check("rc_reads_old", csr_rdata_o, 32'hDEAD_BEFF);
        step(12'h340, 2'd2, 32'h0, 3'b000);
        check("rc_result", csr_rdata_o, 32'h0000_BEFF);

        step(12'h305, 2'd1, 32'h0000_1003, 3'b000);
        step(12'h305, 2'd2, 32'h0, 3'b000);
        check("mtvec_rd", csr_rdata_o, 32'h1000);
        check("mtvec_o",  mtvec_o, 32'h1000);

        step(12'hF14, 2'd1, 32'h1, 3'b000);
        check("hartid_rw_illegal", {31'b0, csr_illegal_o}, 32'h1);
        check("hartid_rw_rdata",   csr_rdata_o, 32'h0);
        step(12'hF14, 2'd2, 32'h0, 3'b000);
        check("hartid_rs0_legal", {31'b0, csr_illegal_o}, 32'h0);
        check("hartid_rs0_rdata", csr_rdata_o, 32'h5);
        step(12'h7C0, 2'd2, 32'h0, 3'b000);
        check("unmapped_illegal", {31'b0, csr_illegal_o}, 32'h1);
        step(12'h301, 2'd1, 32'hFFFF, 3'b000);
        step(12'h301, 2'd2, 32'h0, 3'b000);
        check("misa_ro", csr_rdata_o, 32'h4000_0100);

        step(12'h300, 2'd1, 32'hFFFF_FFFF, 3'b000);
        step(12'h300, 2'd2, 32'h0, 3'b000);
        check("mstatus_warl", csr_rdata_o, 32'h0000_1888);
        step(12'h300, 2'd1, 32'h0000_0008, 3'b000);
        step(12'h300, 2'd2, 32'h0, 3'b000);
        check("mstatus_mie_only", csr_rdata_o, 32'h0000_1808);

        step(12'h340, 2'd1, 32'h1234, 3'b100);
        step(12'h341, 2'd2, 32'h0, 3'b000);
        check("trap_mepc", csr_rdata_o, 32'h80);
        check("trap_mie",  {31'b0, mie_o}, 32'h0);
        step(12'h342, 2'd2, 32'h0, 3'b000);
        check("trap_mcause", csr_rdata_o, 32'hB);
        step(12'h343, 2'd2, 32'h0, 3'b000);
        check("trap_mtval", csr_rdata_o, 32'h5);
        step(12'h300, 2'd2, 32'h0, 3'b000);
        check("trap_mstatus", csr_rdata_o, 32'h0000_1880);
        step(12'h340, 2'd2, 32'h0, 3'b000);
        check("trap_drops_write", csr_rdata_o, 32'h0000_BEFF);

        step(12'h340, 2'd1, 32'h1, 3'b010);
        step(12'h340, 2'd2, 32'h0, 3'b000);
        check("mret_mie", {31'b0, mie_o}, 32'h1);
        check("mret_drops_write", csr_rdata_o, 32'h0000_BEFF);

`ifdef CSR_COUNTERS_EN
        step(12'hB00, 2'd1, 32'hFFFF_FFFF, 3'b000);
        step(12'hB00, 2'd2, 32'h0, 3'b000);
        check("mcycle_written", csr_rdata_o, 32'hFFFF_FFFF);
        step(12'hB00, 2'd2, 32'h0, 3'b000);
        check("mcycle_wrap_lo", csr_rdata_o, 32'h0);
        step(12'hB80, 2'd2, 32'h0, 3'b000);
        check("mcycleh_carry", csr_rdata_o, 32'h1);
        step(12'hC80, 2'd2, 32'h0, 3'b000);
        check("cycleh_shadow", csr_rdata_o, 32'h1);
        step(12'hC00, 2'd1, 32'h1, 3'b000);
        check("shadow_write_illegal", {31'b0, csr_illegal_o}, 32'h1);

        step(12'hB02, 2'd1, 32'h0, 3'b001);
        for (int i = 0; i < 3; i++) step(12'h000, 2'd0, 32'h0, 3'b001);
        step(12'hB02, 2'd2, 32'h0, 3'b000);
        check("minstret_3", csr_rdata_o, 32'h3);
        step(12'hB02, 2'd1, 32'h10, 3'b001);
        step(12'hC02, 2'd2, 32'h0, 3'b000);
        check("minstret_write_wins", csr_rdata_o, 32'h10);
`else
        for (int i = 0; i < 100; i++) step(12'h000, 2'd0, 32'h0, 3'b001);
        step(12'hB00, 2'd2, 32'h0, 3'b000);
        check("nocnt_mcycle_zero",  csr_rdata_o, 32'h0);
        check("nocnt_mcycle_legal", {31'b0, csr_illegal_o}, 32'h0);
        step(12'hB02, 2'd1, 32'h5, 3'b001);
        step(12'hB02, 2'd2, 32'h0, 3'b000);
        check("nocnt_write_ignored", csr_rdata_o, 32'h0);
`endif

        step(12'h341, 2'd1, 32'h444, 3'b000);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        csr_addr_i = 12'hB00; csr_op_i = 2'd2; csr_wdata_i = 0;
        trap_i = 0; mret_i = 0; retire_i = 0;
        #1;
        check("midrst_mie",   {31'b0, mie_o}, 32'h0);
        check("midrst_mtvec", mtvec_o, 32'h204);
        check("midrst_mepc",  mepc_o, 32'h0);
        check("midrst_cycle", csr_rdata_o, 32'h0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        step(12'h340, 2'd2, 32'h0, 3'b000);
        check("midrst_mscratch", csr_rdata_o, 32'h0);
        step(12'h000, 2'd0, 32'h0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
